gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencing controller for a single 2-input logic gate (NOR, NAND, AND, …). On each `start` pulse it drives the gate's `a`/`b` inputs through all four combinations 00, 01, 10, 11 in order. After a programmable settle time it samples the gate output `y` and compares it with a 4-entry expected truth table. It sits between a gate instance and a self-checking top level, and replaces hand-written `#10` stimulus with a clocked, reusable sweep that reports pass/fail per combination.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles `a`/`b` are held before `y` is sampled. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `exp_tt`  in  4  expected output; bit index = {a,b}. NOR = 4'b0001. Latched on accepted start.
- `y`  in  1  gate output under control.
- `a`  out  1  gate input a; registered.
- `b`  out  1  gate input b; registered.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  high when the last completed sweep had no mismatch.
- `fail_mask`  out  4  bit i set when combination i mismatched.

## Operation
- States:
  - IDLE: waits for `start`.
  - SETTLE: counts the settle time.
  - SAMPLE: compares `y` with the expected bit for the current combination.
  - DONE: asserts the completion pulse.
- Reset: state IDLE, `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, combination index 0, settle count 0.
- IDLE with `start`=1 at an edge:
  - latch `exp_tt`; clear `fail_mask` and `pass`.
  - combination index ← 0, {`a`,`b`} ← 00, settle count ← 0, state ← SETTLE.
- SETTLE: settle count increments each edge. At the edge where count = SETTLE_CYCLES−1, state ← SAMPLE.
- SAMPLE, at the edge:
  - `fail_mask[idx]` ← (`y` ≠ latched `exp_tt[idx]`).
  - If idx = 3: state ← DONE.
  - Otherwise: idx ← idx+1, {`a`,`b`} ← new idx, settle count ← 0, state ← SETTLE.
- DONE: `done`=1 for exactly this cycle, `pass` ← ~|`fail_mask` (final value). Next edge: state ← IDLE.
- `a`/`b` hold at 11 after the sweep until the next accepted start or reset.
- `start` is ignored in SETTLE, SAMPLE and DONE; no queuing.
- `pass`/`fail_mask` hold their values until the next accepted start or reset.
- `y` is treated as synchronous; the settle time is what absorbs the gate delay.

## Timing
- Each combination is driven for SETTLE_CYCLES+1 cycles. `y` is sampled at the edge ending the SAMPLE cycle, after `a`/`b` have been stable for SETTLE_CYCLES+1 cycles.
- Start accepted at edge E0: `done` is high in the cycle beginning 4·(SETTLE_CYCLES+1) edges after E0.
  - SETTLE_CYCLES=2: 12 cycles.
  - SETTLE_CYCLES=1: 8 cycles.
- `busy` rises in the cycle after E0 and falls in the DONE cycle.
- Back-to-back sweeps: `start` must arrive in IDLE. Minimum start-to-start spacing is 4·(SETTLE_CYCLES+1)+2 cycles.
- Reset mid-sweep (any state): next cycle shows reset values; partial results are discarded and `done` does not fire.
- Reset and `start` asserted in the same cycle: reset wins; start is dropped.
- Changing `exp_tt` during a sweep has no effect; only the latched value is used.

## Structure
- Shared package `gate_ctrl_pkg`:
  - state enum (IDLE, SETTLE, SAMPLE, DONE).
  - `NUM_COMBOS` = 4, combination index width = 2.
  - named truth-table constants: TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- Single module, no sub-module. The settle counter is an 8-bit register inside the FSM.
- Top-level usage: instantiate the gate next to this controller, tie `a`/`b`/`y`, and drive `start`/`exp_tt` from the bench or a higher-level scheduler.

## Test plan
- NOR gate, `exp_tt`=TT_NOR, SETTLE_CYCLES=2, start pulse → `a`/`b` sequence 00,01,10,11 held 3 cycles each; `done` 12 cycles after the start edge; `pass`=1; `fail_mask`=0000.
- AND gate with `exp_tt`=TT_NOR → `pass`=0, `fail_mask`=1001.
- `start` re-pulsed in cycles 3 and 7 of a sweep → ignored; exactly one `done`, timing unchanged.
- `rst` asserted in cycle 5 of a sweep → next cycle `busy`=0, `a`=`b`=0, `fail_mask`=0, `pass`=0; no `done`. A fresh start completes normally.
- SETTLE_CYCLES=1, two sweeps with minimum spacing (NOR, then a NAND gate with TT_NAND) → `done` at 8 cycles each; both `pass`=1; `fail_mask` cleared at the second start.
- `exp_tt` changed from TT_NOR to 4'b1111 mid-sweep on a NOR gate → `pass`=1, because the latched table is used.

Source files
------------

// File: rtl/gate_ctrl_pkg.sv
// Shared definitions for the gate sweep controller: FSM state type,
// sweep geometry and named 2-input truth tables (bit index = {a,b}).
package gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_COMBOS = 4;
  localparam int unsigned IDX_W      = 2;

  localparam logic [NUM_COMBOS-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_COMBOS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_COMBOS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_COMBOS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_COMBOS-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through {a,b} = 00,01,10,11, holds each combination
// for SETTLE_CYCLES+1 cycles, samples y at the end of that window and
// compares it with the truth table latched at start.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a sweep (accepted only when idle)
//   exp_tt    expected truth table, bit index = {a,b}; latched on start
//   y         gate output under test
//   a, b      registered gate inputs
//   busy      high while settling or sampling
//   done      one-cycle completion pulse
//   pass      last completed sweep had no mismatch
//   fail_mask bit i set when combination i mismatched
module gate_sweep_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_COMBOS-1:0] exp_tt,
  input  logic                  y,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_COMBOS-1:0] fail_mask
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_COMBOS - 1);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_inc;
  logic [7:0]              settle_cnt;
  logic [NUM_COMBOS-1:0]   exp_q;
  logic [NUM_COMBOS-1:0]   mask_upd;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    idx_inc    = idx + 2'd1;
    mask_upd   = fail_mask;
    mask_upd[idx] = y ^ exp_q[idx];

    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy = 1'b1;
        state_next = (idx == IDX_LAST) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      exp_q      <= '0;
      fail_mask  <= '0;
      pass       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q      <= exp_tt;
            fail_mask  <= '0;
            pass       <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
        end
        ST_SAMPLE: begin
          fail_mask <= mask_upd;
          if (idx == IDX_LAST) begin
            // Pass is derived from the mask including the final sample so it
            // is already valid in the cycle done is high.
            pass <= ~|mask_upd;
          end else begin
            idx        <= idx_inc;
            {a, b}     <= idx_inc;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;
  import gate_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, start_v;
  logic [3:0] exp_v   [2];
  logic [3:0] gate_tt [2];
  logic [1:0] a_o, b_o, busy_o, done_o, pass_o, y_i;
  logic [3:0] fm_o [2];

  assign y_i[0] = gate_tt[0][{a_o[0], b_o[0]}];
  assign y_i[1] = gate_tt[1][{a_o[1], b_o[1]}];

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .exp_tt(exp_v[0]), .y(y_i[0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail_mask(fm_o[0])
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .exp_tt(exp_v[1]), .y(y_i[1]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail_mask(fm_o[1])
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: n = cycles since the accepted start edge (-1 when idle). Each
  // combination c occupies cycles [c*W, (c+1)*W) with W = SETTLE_CYCLES+1;
  // its result becomes visible from cycle (c+1)*W; done is cycle 4*W.
  int         n     [2];
  int         win   [2];
  logic [3:0] exp_l [2];
  logic [3:0] gt_l  [2];
  logic [3:0] hmask [2];
  logic       hpass [2];
  logic [1:0] hab   [2];
  int         dcnt  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        n[i] = -1; hab[i] = 2'b00; hmask[i] = 4'b0000; hpass[i] = 1'b0;
      end else if (n[i] < 0) begin
        if (start_v[i]) begin
          n[i] = 0; exp_l[i] = exp_v[i]; gt_l[i] = gate_tt[i];
        end
      end else if (n[i] == 4 * win[i]) begin
        n[i] = -1; hab[i] = 2'b11;
        hmask[i] = gt_l[i] ^ exp_l[i];
        hpass[i] = (hmask[i] == 4'b0000);
      end else begin
        n[i] = n[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_o[i] === 1'b1) dcnt[i]++;
      if (chk_en) begin
        logic eb, ed, ep;
        logic [1:0] eab;
        logic [3:0] em, full;
        full = gt_l[i] ^ exp_l[i];
        if (n[i] < 0) begin
          eb = 0; ed = 0; eab = hab[i]; em = hmask[i]; ep = hpass[i];
        end else if (n[i] < 4 * win[i]) begin
          eb = 1; ed = 0; ep = 0;
          eab = 2'(n[i] / win[i]);
          em = 4'b0000;
          for (int c = 0; c < 4; c++)
            if ((c + 1) * win[i] <= n[i]) em[c] = full[c];
        end else begin
          eb = 0; ed = 1; eab = 2'b11; em = full; ep = (full == 4'b0000);
        end
        chk($sformatf("busy%0d", i), busy_o[i], eb);
        chk($sformatf("done%0d", i), done_o[i], ed);
        chk($sformatf("ab%0d", i), {a_o[i], b_o[i]}, eab);
        chk($sformatf("pass%0d", i), pass_o[i], ep);
        chk($sformatf("fail_mask%0d", i), fm_o[i], em);
      end
    end
  end

  task automatic pulse_start(input int i, input logic [3:0] e);
    start_v[i] = 1'b1;
    exp_v[i]   = e;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int k0, output int lat);
    int k = k0;
    while (done_o[i] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  initial begin
    int lat, d0;
    win[0] = 3; win[1] = 2;
    for (int i = 0; i < 2; i++) begin
      n[i] = -1; dcnt[i] = 0; exp_l[i] = '0; gt_l[i] = '0;
      hmask[i] = '0; hpass[i] = 0; hab[i] = '0;
      exp_v[i] = '0; gate_tt[i] = TT_NOR;
    end
    rst_v = 2'b11; start_v = 2'b00;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_v = 2'b00;
    chk("rst_busy", busy_o, 2'b00);
    chk("rst_a", a_o, 2'b00);
    chk("rst_b", b_o, 2'b00);
    chk("rst_pass", pass_o, 2'b00);
    chk("rst_fm0", fm_o[0], 4'b0000);

    // NOR gate, NOR table, SETTLE=2
    gate_tt[0] = TT_NOR;
    pulse_start(0, TT_NOR);
    wait_done(0, 0, lat);
    chk("nor_latency", lat, 12);
    chk("nor_pass", pass_o[0], 1'b1);
    chk("nor_fm", fm_o[0], 4'b0000);
    @(negedge clk);
    chk("hold_ab", {a_o[0], b_o[0]}, 2'b11);

    // AND gate against NOR table
    gate_tt[0] = TT_AND;
    pulse_start(0, TT_NOR);
    wait_done(0, 0, lat);
    chk("and_latency", lat, 12);
    chk("and_pass", pass_o[0], 1'b0);
    chk("and_fm", fm_o[0], 4'b1001);
    @(negedge clk);

    // start re-pulsed in cycles 3 and 7
    gate_tt[0] = TT_NOR;
    d0 = dcnt[0];
    pulse_start(0, TT_NOR);
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 8, lat);
    chk("ignore_latency", lat, 12);
    repeat (15) @(negedge clk);
    chk("ignore_done_count", dcnt[0] - d0, 1);

    // reset mid-sweep
    d0 = dcnt[0];
    pulse_start(0, TT_NOR);
    repeat (5) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("midrst_busy", busy_o[0], 1'b0);
    chk("midrst_ab", {a_o[0], b_o[0]}, 2'b00);
    chk("midrst_fm", fm_o[0], 4'b0000);
    chk("midrst_pass", pass_o[0], 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", dcnt[0] - d0, 0);
    pulse_start(0, TT_NOR);
    wait_done(0, 0, lat);
    chk("after_rst_latency", lat, 12);
    chk("after_rst_pass", pass_o[0], 1'b1);
    @(negedge clk);

    // reset and start together: reset wins
    rst_v[0] = 1'b1; start_v[0] = 1'b1; exp_v[0] = TT_NOR;
    @(negedge clk);
    rst_v[0] = 1'b0; start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", busy_o[0], 1'b0);

    // SETTLE=1: failing sweep, then NOR and NAND at minimum spacing
    gate_tt[1] = TT_AND;
    pulse_start(1, TT_NOR);
    wait_done(1, 0, lat);
    chk("s1_and_latency", lat, 8);
    chk("s1_and_fm", fm_o[1], 4'b1001);
    @(negedge clk);
    gate_tt[1] = TT_NOR;
    pulse_start(1, TT_NOR);
    chk("s1_fm_cleared", fm_o[1], 4'b0000);
    wait_done(1, 0, lat);
    chk("s1_nor_latency", lat, 8);
    chk("s1_nor_pass", pass_o[1], 1'b1);
    @(negedge clk);
    gate_tt[1] = TT_NAND;
    pulse_start(1, TT_NAND);
    wait_done(1, 0, lat);
    chk("s1_nand_latency", lat, 8);
    chk("s1_nand_pass", pass_o[1], 1'b1);
    chk("s1_nand_fm", fm_o[1], 4'b0000);
    @(negedge clk);

    // exp_tt changed mid-sweep
    gate_tt[0] = TT_NOR;
    pulse_start(0, TT_NOR);
    repeat (4) @(negedge clk);
    exp_v[0] = 4'b1111;
    wait_done(0, 4, lat);
    chk("exp_change_latency", lat, 12);
    chk("exp_change_pass", pass_o[0], 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
